hex_debug_display: RTL and testbench

Parametrised debug-display controller for the FPGA top level. It replaces the fixed single-register hex readout: it accepts several internal data channels, such as result, PC and flags. Two debounced push-buttons step through the channels and freeze a snapshot. The selected value drives active-low 7-segment digits, with optional leading-zero blanking.

---
 rtl/hex_debug_display.sv | 82 ++++++++
 tb/tb_hex_debug_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_debug_display.sv
// hex_debug_display: selectable multi-channel hex readout with debounced next/freeze buttons
module hex_debug_display #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLANK_LZ = 0,
    localparam int NUM_DIGITS = DATA_WIDTH / 4,
    localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic                         btn_next,
    input  logic                         btn_freeze,
    output logic [7*NUM_DIGITS-1:0]      hex_out,
    output logic [SEL_W-1:0]             ch_sel,
    output logic                         frozen
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0][6:0] SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    logic [1:0]          raw;
    logic [1:0][1:0]     sync;
    logic [1:0][CW-1:0]  cnt;
    logic [1:0]          stable;
    logic [1:0]          pulse;
    logic [DATA_WIDTH-1:0] disp_reg;
    assign raw = {btn_freeze, btn_next};
    // Synchronise each button, accept a level only after DEBOUNCE_CYCLES stable samples, pulse on accepted rise
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= '0;
            pulse  <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                sync[b]  <= {sync[b][0], raw[b]};
                pulse[b] <= 1'b0;
                if (sync[b][1] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_MAX) begin
                    cnt[b]    <= '0;
                    stable[b] <= sync[b][1];
                    pulse[b]  <= sync[b][1];
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end
    // Freeze toggles take priority; a next press only advances the channel while live
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_sel <= '0;
            frozen <= 1'b0;
        end else if (pulse[1]) begin
            frozen <= ~frozen;
        end else if (pulse[0] && !frozen) begin
            ch_sel <= (ch_sel == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
        end
    end
    // Track the selected channel while live; hold from the freeze edge until live tracking resumes
    always_ff @(posedge clk) begin
        if (reset) disp_reg <= '0;
        else if (!(frozen || pulse[1])) disp_reg <= ch_data[ch_sel*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic blank;
        if (d == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_msd
            assign blank = BLANK_LZ != 0 && disp_reg[DATA_WIDTH-1:4*d] == '0;
        end
        assign hex_out[7*d +: 7] = blank ? 7'h7f : SEG[disp_reg[4*d +: 4]];
    end
endmodule

// File: tb/tb_hex_debug_display.sv
// tb_hex_debug_display: table vectors, directed sequences and a randomized reference model for hex_debug_display
module tb_hex_debug_display;
    localparam int D = 4;
    localparam int NCH = 3;
    localparam logic [6:0] SEGT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef struct {
        logic [15:0] v;
        logic [27:0] plain;
        logic [27:0] blank;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bn = 1'b0;
    logic bf = 1'b0;
    logic [47:0] chd = '0;
    logic [63:0] chdb = '0;
    logic [27:0] hex, hexb;
    logic [1:0] sel, selb;
    logic frz, frzb;
    int nvec = 0;
    int nfail = 0;

    int m_sel;
    bit m_frz, pn, pf, sn, sf;
    logic [15:0] m_disp;
    bit hn[$];
    bit hf[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    hex_debug_display #(.DATA_WIDTH(16), .NUM_CH(NCH), .DEBOUNCE_CYCLES(D), .BLANK_LZ(0)) dut (
        .clk(clk), .reset(reset), .ch_data(chd), .btn_next(bn), .btn_freeze(bf),
        .hex_out(hex), .ch_sel(sel), .frozen(frz)
    );

    hex_debug_display #(.DATA_WIDTH(16), .NUM_CH(4), .DEBOUNCE_CYCLES(D), .BLANK_LZ(1)) dutb (
        .clk(clk), .reset(reset), .ch_data(chdb), .btn_next(1'b0), .btn_freeze(1'b0),
        .hex_out(hexb), .ch_sel(selb), .frozen(frzb)
    );

    function automatic logic [27:0] exp_hex(input logic [15:0] v);
        logic [27:0] r;
        for (int d = 0; d < 4; d++) r[7*d +: 7] = SEGT[v[4*d +: 4]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // A button level is accepted once the last D synchronised samples all differ from the stable level
    task automatic win(input bit q[$], inout bit s, output bit p);
        bit all_diff;
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (q[i] == s) all_diff = 1'b0;
        p = all_diff && !s;
        if (all_diff) s = !s;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_sel = 0;
            m_frz = 0;
            m_disp = '0;
            pn = 0;
            pf = 0;
            sn = 0;
            sf = 0;
            hn = {};
            hf = {};
            repeat (D + 2) begin
                hn.push_back(1'b0);
                hf.push_back(1'b0);
            end
        end else begin
            int os;
            bit ofz, opn, opf;
            os = m_sel;
            ofz = m_frz;
            opn = pn;
            opf = pf;
            if (!(ofz || opf)) m_disp = chd[os*16 +: 16];
            if (opf) m_frz = !ofz;
            else if (opn && !ofz) m_sel = (os + 1) % NCH;
            hn.push_back(bn);
            hf.push_back(bf);
            void'(hn.pop_front());
            void'(hf.pop_front());
            win(hn, sn, pn);
            win(hf, sf, pf);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {sel, frz, hex}, {2'(m_sel), m_frz, exp_hex(m_disp)});
    endtask

    task automatic press(input bit n, input bit f);
        bn = n;
        bf = f;
        repeat (10) tick();
        bn = 0;
        bf = 0;
        repeat (10) tick();
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        int s0;
        bit f0;
        tbl[0] = '{16'hA5F1, {7'b0001000, 7'b0010010, 7'b0001110, 7'b1111001},
                             {7'b0001000, 7'b0010010, 7'b0001110, 7'b1111001}};
        tbl[1] = '{16'h0040, {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000},
                             {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}};
        tbl[2] = '{16'h0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                             {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        tbl[3] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                             {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[4] = '{16'h0E0B, {7'b1000000, 7'b0000110, 7'b1000000, 7'b0000011},
                             {7'b1111111, 7'b0000110, 7'b1000000, 7'b0000011}};
        tbl[5] = '{16'h000F, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0001110},
                             {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001110}};
        exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};

        @(negedge clk);
        reset = 1;
        repeat (3) tick();
        chk("reset_sel", sel, 2'd0);
        chk("reset_frozen", frz, 1'b0);
        chk("reset_hex", hex, {4{7'b1000000}});
        chk("reset_hex_blank", hexb, {{3{7'b1111111}}, 7'b1000000});
        reset = 0;

        for (int i = 0; i < 6; i++) begin
            chd[15:0] = tbl[i].v;
            chdb[15:0] = tbl[i].v;
            tick();
            chk("table_plain", hex, tbl[i].plain);
            chk("table_blank", hexb, tbl[i].blank);
        end

        chd = {16'hBEEF, 16'h1234, 16'hA5F1};
        for (int i = 0; i < 4; i++) begin
            press(1, 0);
            chk("wrap_sel", sel, exp_seq[i]);
        end

        for (int i = 0; i < 20; i++) begin
            bn = ((i / 2) % 2 == 0);
            tick();
        end
        bn = 0;
        repeat (8) tick();
        chk("bounce_sel", sel, 2'd1);
        bn = 1;
        repeat (3) tick();
        bn = 0;
        repeat (8) tick();
        chk("short_sel", sel, 2'd1);

        press(0, 1);
        chk("freeze_on", frz, 1'b1);
        chd[31:16] = 16'hFFFF;
        repeat (3) tick();
        press(1, 0);
        chk("frozen_sel", sel, 2'd1);
        chk("frozen_hex", hex, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        press(0, 1);
        chk("freeze_off", frz, 1'b0);
        chk("live_hex", hex, {4{7'b0001110}});

        repeat (60) begin
            bn = 1'($urandom_range(0, 1));
            bf = ($urandom_range(0, 3) == 0);
            chd[31:0] = $urandom;
            chd[47:32] = 16'($urandom);
            repeat ($urandom_range(1, 9)) tick();
        end
        bn = 0;
        bf = 0;
        repeat (15) tick();

        s0 = m_sel;
        f0 = m_frz;
        press(1, 1);
        chk("simul_sel", sel, 2'(s0));
        chk("simul_frozen", frz, !f0);
        if (!m_frz) press(0, 1);
        chk("pre_reset_frozen", frz, 1'b1);
        bn = 1;
        repeat (3) tick();
        reset = 1;
        bn = 0;
        tick();
        chk("midreset_sel", sel, 2'd0);
        chk("midreset_frozen", frz, 1'b0);
        chk("midreset_hex", hex, {4{7'b1000000}});
        reset = 0;
        repeat (12) tick();
        chk("no_stray_sel", sel, 2'd0);
        chk("no_stray_frozen", frz, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
